button_reader: RTL and testbench

Debounced push-button input block for the iCEstick LED demos. It samples one raw, asynchronous button pin and synchronises and debounces it. It emits a clean level plus single-cycle press, release and (optionally) long-press strobes. A 5-bit press counter drives D1..D5 directly, so the board shows the number of presses.

---
 rtl/button_reader_if.sv | 16 +
 rtl/button_reader.sv | 120 ++++++++++++
 tb/tb_button_reader.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/button_reader_if.sv
// button_reader_if: raw button pin in; debounced level, strobes and press count out (long_pulse only with BUTTON_READER_LONGPRESS_EN)
interface button_reader_if;
   logic       btn_in;
   logic       btn_level;
   logic       press_pulse;
   logic       release_pulse;
   logic [4:0] press_count;
`ifdef BUTTON_READER_LONGPRESS_EN
   logic       long_pulse;
   modport master (output btn_in, input btn_level, press_pulse, release_pulse, long_pulse, press_count);
   modport slave (input btn_in, output btn_level, press_pulse, release_pulse, long_pulse, press_count);
`else
   modport master (output btn_in, input btn_level, press_pulse, release_pulse, press_count);
   modport slave (input btn_in, output btn_level, press_pulse, release_pulse, press_count);
`endif
endinterface

// File: rtl/button_reader.sv
// button_reader: synchronised, debounced push button with press/release strobes and a 5-bit press counter; long-press strobe compiled in by BUTTON_READER_LONGPRESS_EN
module button_reader #(
   parameter int DEBOUNCE_CYCLES = 120000,
   parameter int LONG_CYCLES     = 12000000,
   parameter bit ACTIVE_LOW      = 1'b1
) (
   input logic            clk,
   input logic            rst_n,
   button_reader_if.slave bus
);
`ifdef BUTTON_READER_LONGPRESS_EN
   localparam int MAXC = (DEBOUNCE_CYCLES > LONG_CYCLES) ? DEBOUNCE_CYCLES : LONG_CYCLES;
`else
   localparam int MAXC = DEBOUNCE_CYCLES;
`endif
   localparam int CW = $clog2(MAXC + 1);
   localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
`ifdef BUTTON_READER_LONGPRESS_EN
   localparam logic [CW-1:0] LONG_V    = CW'(LONG_CYCLES);
   localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
`endif
   typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;
   state_t        state;
   logic [CW-1:0] cnt;
   logic [1:0]    sync;
   logic          s;
   logic          level;
   logic          press_p;
   logic          release_p;
   logic [4:0]    count;
`ifdef BUTTON_READER_LONGPRESS_EN
   logic          long_p;
   logic          long_done;
   assign bus.long_pulse = long_p;
`endif
   assign s                 = sync[1] ^ ACTIVE_LOW;
   assign bus.btn_level     = level;
   assign bus.press_pulse   = press_p;
   assign bus.release_pulse = release_p;
   assign bus.press_count   = count;

   // two-flop synchroniser, idling at the released pin level
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) sync <= {2{ACTIVE_LOW}};
      else        sync <= {sync[0], bus.btn_in};

   // debounce FSM with registered level, strobes and press counter
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state     <= RELEASED;
         cnt       <= '0;
         level     <= 1'b0;
         press_p   <= 1'b0;
         release_p <= 1'b0;
         count     <= '0;
`ifdef BUTTON_READER_LONGPRESS_EN
         long_p    <= 1'b0;
         long_done <= 1'b0;
`endif
      end else begin
         press_p   <= 1'b0;
         release_p <= 1'b0;
`ifdef BUTTON_READER_LONGPRESS_EN
         long_p    <= 1'b0;
`endif
         case (state)
            RELEASED:
               if (s) begin
                  state <= PRESS_WAIT;
                  cnt   <= CW'(1);
               end
            PRESS_WAIT:
               if (!s) begin
                  state <= RELEASED;
                  cnt   <= '0;
`ifdef BUTTON_READER_LONGPRESS_EN
                  long_done <= 1'b0;
`endif
               end else if (cnt == DB_LAST) begin
                  state   <= PRESSED;
                  cnt     <= '0;
                  level   <= 1'b1;
                  press_p <= 1'b1;
                  count   <= count + 5'd1;
               end else cnt <= cnt + 1'b1;
            PRESSED:
               if (!s) begin
                  state <= RELEASE_WAIT;
                  cnt   <= CW'(1);
               end
`ifdef BUTTON_READER_LONGPRESS_EN
               else begin
                  if (cnt != LONG_V) cnt <= cnt + 1'b1;
                  if (cnt == LONG_LAST && !long_done) begin
                     long_p    <= 1'b1;
                     long_done <= 1'b1;
                  end
               end
`endif
            RELEASE_WAIT:
               if (s) begin
                  state <= PRESSED;
`ifdef BUTTON_READER_LONGPRESS_EN
                  cnt   <= LONG_V;
`else
                  cnt   <= '0;
`endif
               end else if (cnt == DB_LAST) begin
                  state     <= RELEASED;
                  cnt       <= '0;
                  level     <= 1'b0;
                  release_p <= 1'b1;
`ifdef BUTTON_READER_LONGPRESS_EN
                  long_done <= 1'b0;
`endif
               end else cnt <= cnt + 1'b1;
            default: state <= RELEASED;
         endcase
      end
endmodule

// File: tb/tb_button_reader.sv
// tb_button_reader: scoreboard bench for button_reader (long-press checks compiled with BUTTON_READER_LONGPRESS_EN)
`timescale 1ns/1ps
module tb_button_reader;
   localparam int D   = 4;
   localparam int L   = 10;
   localparam int LAT = D + 2;
   typedef struct {int kind; int at; int cnt;} ev_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic long_s;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   int   exp_cnt = 0;
   ev_t  q[$];
   button_reader_if bus();
   button_reader #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .ACTIVE_LOW(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus));
`ifdef BUTTON_READER_LONGPRESS_EN
   assign long_s = bus.long_pulse;
`else
   assign long_s = 1'b0;
`endif
   always #41.667 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input int kind, input int at, input int c);
      ev_t e;
      e.kind = kind;
      e.at = at;
      e.cnt = c;
      q.push_back(e);
   endtask

   task automatic start_press(input bit long_expected);
      @(negedge clk);
      bus.btn_in = 1'b0;
      exp_cnt = (exp_cnt + 1) % 32;
      push(0, cyc + LAT, exp_cnt);
`ifdef BUTTON_READER_LONGPRESS_EN
      if (long_expected) push(2, cyc + LAT + L, 0);
`endif
   endtask

   task automatic end_press();
      bus.btn_in = 1'b1;
      push(1, cyc + LAT, 0);
   endtask

   task automatic press(input int hold);
      start_press(hold >= L + 4);
      tick(hold);
      end_press();
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && q.size() > 0; i++) tick(1);
      chk("drain", q.size(), 0);
      tick(8);
   endtask

   // every strobe is matched against the oldest expected event
   always @(negedge clk) begin : mon
      int k;
      ev_t e;
      if (rst_n && (bus.press_pulse || bus.release_pulse || long_s)) begin
         k = bus.press_pulse ? 0 : bus.release_pulse ? 1 : 2;
         chk("onehot", int'(bus.press_pulse) + int'(bus.release_pulse) + int'(long_s), 1);
         if (q.size() == 0) chk("spurious_kind", k, 32'hffff_ffff);
         else begin
            e = q.pop_front();
            chk("kind", k, e.kind);
            chk("when", cyc, e.at);
            if (k == 0) begin
               chk("count", bus.press_count, e.cnt);
               chk("level_hi", bus.btn_level, 1);
            end
            if (k == 1) chk("level_lo", bus.btn_level, 0);
         end
      end
   end

   initial begin
      bus.btn_in = 1'b0;
      tick(3);
      chk("rst_level", bus.btn_level, 0);
      chk("rst_count", bus.press_count, 0);
      chk("rst_press", bus.press_pulse, 0);
      chk("rst_release", bus.release_pulse, 0);
      rst_n = 1'b1;
      exp_cnt = 1;
      push(0, cyc + LAT, 1);
      for (int i = 0; i < 2; i++) begin
         tick(1);
         chk("post_rst_level", bus.btn_level, 0);
         chk("post_rst_count", bus.press_count, 0);
      end
      tick(8);
      end_press();
      drain();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus.btn_in = 1'b0;
         tick(3);
         bus.btn_in = 1'b1;
         tick(5);
      end
      tick(10);
      chk("bounce_level", bus.btn_level, 0);
      chk("bounce_count", bus.press_count, exp_cnt);
      press(20);
      drain();
      start_press(1'b0);
      tick(10);
      chk("hold_level", bus.btn_level, 1);
      #20 rst_n = 1'b0;
      #1;
      chk("async_level", bus.btn_level, 0);
      chk("async_count", bus.press_count, 0);
      tick(2);
      rst_n = 1'b1;
      exp_cnt = 1;
      push(0, cyc + LAT, 1);
      tick(8);
      end_press();
      drain();
      for (int i = 0; i < 33; i++) begin
         press(6);
         drain();
      end
      chk("wrap_count", bus.press_count, exp_cnt);
      press(30);
      drain();
      start_press(1'b1);
      tick(20);
      bus.btn_in = 1'b1;
      tick(2);
      bus.btn_in = 1'b0;
      tick(10);
      chk("glitch_level", bus.btn_level, 1);
      end_press();
      drain();
      chk("final_count", bus.press_count, exp_cnt);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
